// File: rtl/button_event_queue.sv
`default_nettype none
// ============================================================================
// Module   : button_event_queue
// Purpose  : Debounces an 8-bit button vector and queues one event (button
//            index) per debounced press into a small FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_queue #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       clr_ovf,
    input  logic       evt_ready,
    output logic       evt_valid,
    output logic [2:0] evt_code,
    output logic [7:0] debounced,
    output logic [7:0] pending,
    output logic       overflow
);
    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES - 1);
    localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

    logic [7:0]    cand;
    logic [7:0]    cnt;
    logic [2:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;

    logic          db_load;
    logic [7:0]    rise;
    logic          pop;
    logic          push;
    logic [2:0]    push_idx;
    logic [7:0]    push_mask;
    logic [7:0]    pend_next;

    // Debounced vector is reloaded every cycle once the candidate has settled.
    assign db_load   = (data_in == cand) && (cnt == CNT_MAX);
    assign rise      = db_load ? (cand & ~debounced) : 8'h00;

    assign evt_valid = (count != '0);
    assign evt_code  = mem[rd_ptr];
    assign pop       = evt_valid && evt_ready;
    assign push      = (pending != 8'h00) && ((count < DEPTH_C) || pop);

    always_comb begin
        push_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) begin
                push_idx = 3'(i);
            end
        end
    end

    assign push_mask = push ? (8'h01 << push_idx) : 8'h00;
    // Rise is OR-ed after the push clear so a same-cycle re-press survives.
    assign pend_next = (pending & ~push_mask) | rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand      <= 8'h00;
            cnt       <= 8'h00;
            debounced <= 8'h00;
        end else if (data_in != cand) begin
            cand <= data_in;
            cnt  <= 8'h00;
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 8'd1;
        end else begin
            debounced <= cand;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            pending <= pend_next;
            if ((rise & pending) != 8'h00) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 3'd0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_idx;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire
